// File: rtl/ann_pkg.sv
// Shared ANN hidden-layer definitions: sequencer state encoding and datapath widths.
package ann_pkg;

    localparam int unsigned ANN_NUM_NEURONS = 20;
    localparam int unsigned ANN_MAC_W       = 32;
    localparam int unsigned ANN_ACT_W       = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSel,
        StOut,
        StDone
    } ann_state_e;

endpackage

// File: rtl/ann_round_sat.sv
// Combinational rescale of a signed accumulator: round-half-up, arithmetic shift,
// saturate to the signed output range.
module ann_round_sat #(
    parameter int unsigned IN_W       = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FRAC_SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  data_i,
    output logic signed [OUT_W-1:0] data_o
);

    localparam logic [IN_W:0] One = 1;
    // Half an output LSB; collapses to zero when no shift is applied.
    localparam logic [IN_W:0] RoundBias = (One << FRAC_SHIFT) >> 1;
    localparam logic signed [IN_W:0] SatMax =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SatMin =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    always_comb begin
        ext     = {data_i[IN_W-1], data_i};
        sum     = ext + $signed(RoundBias);
        shifted = sum >>> FRAC_SHIFT;
        if (shifted > SatMax) begin
            data_o = SatMax[OUT_W-1:0];
        end else if (shifted < SatMin) begin
            data_o = SatMin[OUT_W-1:0];
        end else begin
            data_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/ann_neuron_sequencer.sv
// Walks the MAC-result mux after a MAC window completes, rescales each accumulator
// and streams it downstream over a valid/ready handshake.
module ann_neuron_sequencer
    import ann_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = ANN_NUM_NEURONS,
    parameter int unsigned SEL_W       = 5,
    parameter int unsigned IN_W        = ANN_MAC_W,
    parameter int unsigned OUT_W       = ANN_ACT_W,
    parameter int unsigned FRAC_SHIFT  = 8
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iStart,
    input  logic signed [IN_W-1:0]  iData,
    input  logic                    iReady,
    output logic [SEL_W-1:0]        oSel,
    output logic signed [OUT_W-1:0] oData,
    output logic [SEL_W-1:0]        oIndex,
    output logic                    oValid,
    output logic                    oBusy,
    output logic                    oDone
);

    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_NEURONS - 1);

    ann_state_e              state_q;
    logic [SEL_W-1:0]        idx_q;
    logic [SEL_W-1:0]        index_q;
    logic signed [OUT_W-1:0] data_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [OUT_W-1:0] scaled;

    ann_round_sat #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_round_sat (
        .data_i(iData),
        .data_o(scaled)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (iStart) begin
                        state_q <= StSel;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSel: begin
                    data_q  <= scaled;
                    index_q <= idx_q;
                    valid_q <= 1'b1;
                    state_q <= StOut;
                end
                StOut: begin
                    if (iReady) begin
                        valid_q <= 1'b0;
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + SEL_W'(1);
                            state_q <= StSel;
                        end
                    end
                end
                StDone: begin
                    // idx_q doubles as the mux select, so it is parked at 0 for idle.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oSel   = idx_q;
    assign oData  = data_q;
    assign oIndex = index_q;
    assign oValid = valid_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;

endmodule
